// File: rtl/gpio_conf_bank.sv
// Bank of NUM_CH GPIO config channels with per-channel valid/ready write handshake,
// shadow registers and optional atomic commit. Optional write lock via GPIO_CONF_BANK_LOCK_EN.
module gpio_conf_bank #(
  parameter int                NUM_CH      = 4,
  parameter int                DATA_W      = 24,
  parameter int                COMMIT_MODE = 0,
  parameter logic [DATA_W-1:0] RST_VAL     = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        conf_valid,
  output logic [NUM_CH-1:0]        conf_ready,
  input  logic [NUM_CH*DATA_W-1:0] conf_in,
  output logic [NUM_CH*DATA_W-1:0] conf_out,
  input  logic                     commit,
  output logic [NUM_CH-1:0]        pending,
  output logic [NUM_CH-1:0]        updated
`ifdef GPIO_CONF_BANK_LOCK_EN
  ,
  input  logic                     lock,
  output logic                     lock_err,
  input  logic                     err_clr
`endif
);

  typedef enum logic {IDLE, ACK} hs_state_t;

  logic              lock_w;
  logic [NUM_CH-1:0] accept_vec;

`ifdef GPIO_CONF_BANK_LOCK_EN
  logic lock_err_reg;
  logic lock_err_next;

  assign lock_w = lock;

  // A set in the same cycle as a clear wins so no violation is ever lost.
  always_comb begin
    lock_err_next = lock_err_reg;
    if (err_clr)
      lock_err_next = 1'b0;
    if (lock && (|accept_vec))
      lock_err_next = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      lock_err_reg <= 1'b0;
    else
      lock_err_reg <= lock_err_next;
  end

  assign lock_err = lock_err_reg;
`else
  assign lock_w = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      hs_state_t         state_reg;
      hs_state_t         state_next;
      logic [DATA_W-1:0] din;
      logic [DATA_W-1:0] shadow_reg;
      logic [DATA_W-1:0] shadow_next;
      logic [DATA_W-1:0] out_reg;
      logic              pending_reg;
      logic              pending_next;
      logic              updated_reg;
      logic              write_en;
      logic              apply;

      assign din           = conf_in[gi*DATA_W +: DATA_W];
      assign accept_vec[gi] = (state_reg == ACK) && conf_valid[gi];
      assign write_en      = accept_vec[gi] && !lock_w;
      assign shadow_next   = write_en ? din : shadow_reg;

      always_comb begin
        state_next = state_reg;
        case (state_reg)
          IDLE:    if (conf_valid[gi]) state_next = ACK;
          ACK:     if (conf_valid[gi]) state_next = IDLE;
          default: state_next = IDLE;
        endcase
      end

      // Accepting data is folded into shadow_next, so a same-cycle accept wins over older pending data.
      always_comb begin
        apply        = 1'b0;
        pending_next = 1'b0;
        if (COMMIT_MODE == 0) begin
          apply = write_en;
        end else begin
          apply = commit && (pending_reg || write_en);
          if (apply)
            pending_next = 1'b0;
          else if (write_en)
            pending_next = 1'b1;
          else
            pending_next = pending_reg;
        end
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          state_reg   <= IDLE;
          shadow_reg  <= RST_VAL;
          out_reg     <= RST_VAL;
          pending_reg <= 1'b0;
          updated_reg <= 1'b0;
        end else begin
          state_reg   <= state_next;
          shadow_reg  <= shadow_next;
          pending_reg <= pending_next;
          updated_reg <= apply;
          if (apply)
            out_reg <= shadow_next;
        end
      end

      assign conf_ready[gi]                 = (state_reg == ACK);
      assign pending[gi]                    = pending_reg;
      assign updated[gi]                    = updated_reg;
      assign conf_out[gi*DATA_W +: DATA_W]  = out_reg;
    end
  endgenerate

endmodule
